// File: rtl/shared_net_arbiter_pkg.sv
// Shared definitions for the shared-net round-robin arbiter.
package shared_net_arbiter_pkg;

    // Controller state encoding
    localparam int unsigned STATE_W  = 2;
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_BURST = 2'd1;
    localparam logic [1:0]  ST_TURN  = 2'd2;

    // Turnaround counter covers gaps of 0..3 idle cycles
    localparam int unsigned TCNT_W = 2;

    // Width of a requester index; at least one bit even for two requesters
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/shared_net_arbiter_if.sv
// Requester-side and bus-side handshake bundle for the shared-net arbiter.
interface shared_net_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LEN_W   = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*LEN_W-1:0]  req_len;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        gnt;
    logic                      bus_valid;
    logic [DATA_W-1:0]         bus_data;
    logic                      bus_ready;
    logic                      busy;

    // Requesters plus downstream sink
    modport master (
        output req, req_len, req_data, bus_ready,
        input  req_ready, gnt, bus_valid, bus_data, busy
    );

    // Arbiter side
    modport slave (
        input  req, req_len, req_data, bus_ready,
        output req_ready, gnt, bus_valid, bus_data, busy
    );
endinterface

// File: rtl/shared_net_arbiter_rr_picker.sv
// Combinational round-robin priority encoder: first requester after last_owner wins.
module rr_picker
    import shared_net_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_owner_i,
    output logic [IDX_W-1:0]   pick_o,
    output logic               found_o
);

    int cand;

    // Walk candidates last_owner+1 .. last_owner+NUM_REQ (mod NUM_REQ), keep the first hit
    always_comb begin
        pick_o  = '0;
        found_o = 1'b0;
        cand    = 0;
        for (int k = 1; k <= int'(NUM_REQ); k++) begin
            cand = int'(last_owner_i) + k;
            if (cand >= int'(NUM_REQ)) begin
                cand = cand - int'(NUM_REQ);
            end
            for (int j = 0; j < int'(NUM_REQ); j++) begin
                if (!found_o && (cand == j) && req_i[j]) begin
                    found_o = 1'b1;
                    pick_o  = IDX_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/shared_net_arbiter.sv
// Round-robin owner arbitration of a single shared driven net with bounded bursts
// and a turnaround gap between owners.
module shared_net_arbiter
    import shared_net_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned LEN_W      = 4,
    parameter int unsigned TURNAROUND = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    shared_net_arbiter_if.slave bus_if
);

    localparam int unsigned     IDX_W     = idx_width(NUM_REQ);
    localparam logic [TCNT_W-1:0] TCNT_LOAD =
        (TURNAROUND == 0) ? '0 : TCNT_W'(TURNAROUND - 1);

    logic [STATE_W-1:0] state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   last_owner_q, last_owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [LEN_W-1:0]   beats_q, beats_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;

    logic [IDX_W-1:0]   pick_c;
    logic               found_c;
    logic [LEN_W-1:0]   pick_len_c;
    logic               own_req_c;
    logic [DATA_W-1:0]  own_data_c;
    logic [DATA_W-1:0]  data_c;
    logic [NUM_REQ-1:0] ready_c;
    logic               beat_c;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .req_i        (bus_if.req),
        .last_owner_i (last_owner_q),
        .pick_o       (pick_c),
        .found_o      (found_c)
    );

    // Select the picked requester's length and the current owner's request/data
    always_comb begin
        pick_len_c = '0;
        own_req_c  = 1'b0;
        own_data_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick_c == IDX_W'(i)) begin
                pick_len_c = bus_if.req_len[i*LEN_W +: LEN_W];
            end
            if (owner_q == IDX_W'(i)) begin
                own_req_c  = bus_if.req[i];
                own_data_c = bus_if.req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Bus data and per-requester ready follow the registered owner; zero when idle
    always_comb begin
        data_c  = '0;
        ready_c = '0;
        if (valid_q) begin
            data_c  = own_data_c;
            ready_c = NUM_REQ'(bus_if.bus_ready) << owner_q;
        end
    end

    assign beat_c = valid_q & bus_if.bus_ready;

    // Next-state and registered-output logic for IDLE / BURST / TURN
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        gnt_d        = gnt_q;
        beats_d      = beats_q;
        tcnt_d       = tcnt_q;
        valid_d      = valid_q;
        busy_d       = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (found_c) begin
                    state_d      = ST_BURST;
                    owner_d      = pick_c;
                    last_owner_d = pick_c;
                    gnt_d        = NUM_REQ'(1) << pick_c;
                    beats_d      = pick_len_c;
                    valid_d      = 1'b1;
                    busy_d       = 1'b1;
                end
            end
            ST_BURST: begin
                if (beat_c && (beats_q != '0)) begin
                    beats_d = beats_q - LEN_W'(1);
                end
                // Last beat or owner withdrew; a beat in the same cycle still counts
                if ((beat_c && (beats_q == '0)) || !own_req_c) begin
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    beats_d = '0;
                    if (TURNAROUND == 0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_TURN;
                        tcnt_d  = TCNT_LOAD;
                    end
                end
            end
            ST_TURN: begin
                if (tcnt_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    tcnt_d = tcnt_q - TCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
                busy_d  = 1'b0;
                beats_d = '0;
                tcnt_d  = '0;
            end
        endcase
    end

    // State register; last_owner resets to the top index so requester 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= IDX_W'(NUM_REQ - 1);
            gnt_q        <= '0;
            beats_q      <= '0;
            tcnt_q       <= '0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            gnt_q        <= gnt_d;
            beats_q      <= beats_d;
            tcnt_q       <= tcnt_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus_if.gnt       = gnt_q;
    assign bus_if.bus_valid = valid_q;
    assign bus_if.busy      = busy_q;
    assign bus_if.bus_data  = data_c;
    assign bus_if.req_ready = ready_c;

endmodule

// File: tb/tb_shared_net_arbiter.sv
// Scoreboard bench for shared_net_arbiter: a transaction-level model predicts the
// owner per cycle, a negedge monitor compares every output against it.
module tb_shared_net_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 8;
    localparam int unsigned LW = 4;
    localparam int unsigned TA = 1;
    localparam int unsigned LENS_W = NR * LW;
    localparam int unsigned DATS_W = NR * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shared_net_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW)) bif ();
    shared_net_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW)) bif0 ();

    shared_net_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW), .TURNAROUND(TA)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bif)
    );

    shared_net_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .LEN_W(LW), .TURNAROUND(0)) dut0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_if (bif0)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    typedef struct { int owner; bit busy; } exp_t;
    typedef struct { int owner; int cyc; } glog_t;
    exp_t  expq[$];
    glog_t glog[$];
    int    rdy_cnt [NR];
    logic [NR-1:0] prev_gnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int oh2idx(input logic [NR-1:0] v);
        int r = -1;
        for (int i = 0; i < int'(NR); i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: owner/remaining-beats/gap bookkeeping, one expectation per edge
    initial begin : model
        int m_owner, m_left, m_gap, m_last;
        m_owner = -1; m_left = 0; m_gap = 0; m_last = NR - 1;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_owner = -1; m_left = 0; m_gap = 0; m_last = NR - 1;
                expq.delete();
            end else begin
                if (m_owner >= 0) begin
                    if (bif.bus_ready) m_left--;
                    if (m_left == 0 || !bif.req[m_owner]) begin
                        m_owner = -1;
                        m_gap   = TA;
                    end
                end else if (m_gap > 0) begin
                    m_gap--;
                end else begin
                    for (int k = 1; k <= int'(NR); k++) begin
                        int c;
                        c = (m_last + k) % NR;
                        if (m_owner < 0 && bif.req[c]) begin
                            m_owner = c;
                            m_left  = int'(bif.req_len[c*LW +: LW]) + 1;
                            m_last  = c;
                        end
                    end
                end
                expq.push_back('{m_owner, (m_owner >= 0) || (m_gap > 0)});
            end
        end
    end

    // Monitor: pop one expectation per cycle and compare all outputs
    initial begin : monitor
        exp_t e;
        logic [NR-1:0] eg, er;
        logic [DW-1:0] ed;
        forever begin
            @(negedge clk);
            if (!rst_n || expq.size() == 0) e = '{-1, 1'b0};
            else e = expq.pop_front();
            eg = '0; er = '0; ed = '0;
            if (e.owner >= 0) begin
                eg[e.owner] = 1'b1;
                er[e.owner] = bif.bus_ready;
                ed = bif.req_data[e.owner*DW +: DW];
            end
            check("gnt", 32'(bif.gnt), 32'(eg));
            check("bus_valid", 32'(bif.bus_valid), 32'(e.owner >= 0));
            check("bus_data", 32'(bif.bus_data), 32'(ed));
            check("req_ready", 32'(bif.req_ready), 32'(er));
            check("busy", 32'(bif.busy), 32'(e.busy));
            check("dut0_gnt_onehot", 32'($countones(bif0.gnt) <= 1), 32'd1);
            if (bif.gnt != '0 && bif.gnt != prev_gnt) glog.push_back('{oh2idx(bif.gnt), cyc});
            prev_gnt = bif.gnt;
            for (int i = 0; i < int'(NR); i++) rdy_cnt[i] += int'(bif.req_ready[i]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        glog.delete();
        for (int i = 0; i < int'(NR); i++) rdy_cnt[i] = 0;
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        bif.req = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int t0;
        logic [NR-1:0] r;
        logic [4:0] vpat;
        logic [4:0] vexp;
        bif.req = '0; bif.req_len = '0; bif.req_data = DATS_W'(32'hA1B2C3D4); bif.bus_ready = 1'b1;
        bif0.req = '0; bif0.req_len = '0; bif0.req_data = DATS_W'(32'h11223344); bif0.bus_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state: requester 1 wins over 2 via last_owner = NR-1
        rst_n = 1'b1;
        clr_counts();
        t0 = cyc;
        bif.req = 4'b0110;
        repeat (3) tick();
        check("first_grant_count", 32'(glog.size() >= 1), 32'd1);
        if (glog.size() >= 1) begin
            check("first_grant_owner", 32'(glog[0].owner), 32'd1);
            check("grant_latency", 32'(glog[0].cyc - t0), 32'd1);
        end
        bif.req = '0;
        repeat (6) tick();

        // Round robin, all requesting, single-beat bursts
        do_reset();
        clr_counts();
        bif.req = 4'b1111; bif.req_len = '0; bif.bus_ready = 1'b1;
        repeat (16) tick();
        bif.req = '0;
        check("rr_count", 32'(glog.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i < glog.size()) begin
                check("rr_owner", 32'(glog[i].owner), 32'(i % NR));
                if (i > 0) check("rr_spacing", 32'(glog[i].cyc - glog[i-1].cyc), 32'd3);
            end
        end
        repeat (6) tick();

        // Burst with stalls on requester 2
        clr_counts();
        bif.req_len = '0;
        bif.req_len[2*LW +: LW] = LW'(3);
        bif.req_data[2*DW +: DW] = 8'h5C;
        bif.req = 4'b0100;
        foreach (vpat[i]) ;
        for (int i = 0; i < 6; i++) begin
            logic [5:0] rp;
            rp = 6'b101101;
            tick();
            bif.bus_ready = rp[i];
        end
        tick();
        bif.req = '0;
        bif.bus_ready = 1'b1;
        repeat (3) tick();
        check("burst_beats_req2", 32'(rdy_cnt[2]), 32'd4);
        check("burst_beats_other", 32'(rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[3]), 32'd0);
        check("burst_grants", 32'(glog.size()), 32'd1);

        // Abort: requester 0 drops after one beat, requester 1 follows
        clr_counts();
        bif.req_len = '0;
        bif.req_len[0 +: LW] = LW'(4);
        bif.req = 4'b0011;
        tick();
        bif.bus_ready = 1'b1;
        tick();
        bif.req = 4'b0010;
        bif.bus_ready = 1'b0;
        tick();
        bif.bus_ready = 1'b1;
        repeat (4) tick();
        bif.req = '0;
        repeat (4) tick();
        check("abort_beats_req0", 32'(rdy_cnt[0]), 32'd1);
        check("abort_grants", 32'(glog.size() >= 2), 32'd1);
        if (glog.size() >= 2) begin
            check("abort_first", 32'(glog[0].owner), 32'd0);
            check("abort_next", 32'(glog[1].owner), 32'd1);
            check("abort_gap", 32'(glog[1].cyc - glog[0].cyc), 32'd4);
        end

        // Asynchronous reset in the middle of a burst
        bif.req_len = '0;
        bif.req_len[3*LW +: LW] = LW'(5);
        bif.req = 4'b1000;
        repeat (3) tick();
        @(negedge clk);
        #2;
        check("pre_reset_valid", 32'(bif.bus_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_gnt", 32'(bif.gnt), 32'd0);
        check("async_valid", 32'(bif.bus_valid), 32'd0);
        check("async_data", 32'(bif.bus_data), 32'd0);
        check("async_ready", 32'(bif.req_ready), 32'd0);
        check("async_busy", 32'(bif.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        clr_counts();
        bif.req = 4'b1111; bif.req_len = '0;
        repeat (3) tick();
        check("post_reset_grants", 32'(glog.size() >= 1), 32'd1);
        if (glog.size() >= 1) check("post_reset_owner", 32'(glog[0].owner), 32'd0);
        bif.req = '0;
        repeat (4) tick();

        // Randomized traffic
        r = '0;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < int'(NR); i++) begin
                if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
                bif.req_len[i*LW +: LW] = LW'($urandom_range(0, 5));
            end
            bif.req       = r;
            bif.req_data  = DATS_W'($urandom);
            bif.bus_ready = ($urandom_range(0, 3) != 0);
        end
        bif.req = '0;
        repeat (12) tick();

        // Zero turnaround: one idle cycle between owners, never two grants
        bif0.req_len = '0; bif0.bus_ready = 1'b1;
        bif0.req = 4'b0011;
        @(posedge clk);
        vexp = 5'b10101;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vpat[4-i] = bif0.bus_valid;
            if (i == 0) check("ta0_gnt_first", 32'(bif0.gnt), 32'h1);
            if (i == 2) check("ta0_gnt_second", 32'(bif0.gnt), 32'h2);
        end
        check("ta0_valid_pattern", 32'(vpat), 32'(vexp));
        tick();
        bif0.req = '0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_net_arbiter.md
# shared_net_arbiter

Round-robin arbiter that shares one driven net, a single source feeding loads in the top module and inside child hierarchy, among NUM_REQ requesters. It grants one requester at a time for a bounded burst of beats and forwards that requester's data onto the shared bus under a valid/ready handshake. Between owners it inserts a configurable turnaround gap so that no two drivers overlap. It sits in front of the shared fanout tree and replaces ad-hoc muxing of the driver input.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, bus data width
- LEN_W, 4, burst-length field width; burst = len+1 beats
- TURNAROUND, 1, idle cycles between owners (0..3)

- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- req  in  NUM_REQ  request per requester, level
- req_len  in  NUM_REQ*LEN_W  burst length per requester, sampled at grant
- req_data  in  NUM_REQ*DATA_W  data per requester, slice i belongs to requester i
- req_ready  out  NUM_REQ  beat accepted for requester i
- gnt  out  NUM_REQ  one-hot grant, registered
- bus_valid  out  1  shared bus carries a beat
- bus_data  out  DATA_W  shared bus data
- bus_ready  in  1  downstream accepts beat
- busy  out  1  high outside IDLE

## Operation
- States: IDLE, BURST, TURN.
- IDLE: when any req is high, the rr_picker selects the first requester after last_owner, wrapping modulo NUM_REQ. Next edge: owner<=pick, gnt<=onehot(pick), beats<=req_len[pick], last_owner<=pick, state<=BURST.
- BURST: bus_valid=1. bus_data=req_data[owner] (combinational mux on registered owner). req_ready[owner]=bus_ready; all other req_ready are 0. A beat is bus_valid&&bus_ready.
  - Beat with beats==0: last beat; go to TURN, or to IDLE if TURNAROUND==0; gnt<=0.
  - Beat with beats>0: beats<=beats-1.
  - req[owner] low at an edge with no beat: abort; gnt<=0; go to TURN/IDLE as for the last beat. A beat in the same cycle completes first and is counted.
- TURN: gnt=0, bus_valid=0, tcnt counts TURNAROUND-1 down to 0, then IDLE. New requests are ignored until IDLE.
- Fairness: last_owner advances only on grant, so every continuously requesting requester is granted within NUM_REQ grants.
- bus_data holds 0 when bus_valid=0.

## Timing
- Reset (async, any state): state=IDLE, gnt=0, bus_valid=0, bus_data=0, req_ready=0, busy=0, beats=0, tcnt=0, last_owner=NUM_REQ-1, so requester 0 wins first.
- Grant latency: req sampled high in IDLE at edge k gives gnt and bus_valid high from cycle k+1.
- Throughput: one beat per cycle while bus_ready=1. A burst of L+1 beats with no stall occupies L+1 cycles, then TURNAROUND cycles, then IDLE for 1 cycle minimum. Back-to-back owner spacing is L+1+TURNAROUND+1 cycles.
- Stalls: bus_ready low holds bus_valid, bus_data and beats. There is no timeout.
- Simultaneous requests in IDLE resolve in a single cycle by rotating priority.
- Deassertion of rst_n is synchronized outside this block. The block leaves IDLE only on the first clk edge after release.

## Structure
- Package shared_net_arbiter_pkg holds the state enum (IDLE, BURST, TURN) and a localparam function for the owner index width, clog2(NUM_REQ).
- One sub-module, rr_picker: combinational round-robin priority encoder with inputs req and last_owner and outputs pick and found. It is reusable by other resizer test controllers.
- All state is in the top; there are no other sub-modules.

## Test plan
- Reset state: reset, then req=4'b0110. Required: gnt=4'b0010 one cycle later (requester 1 wins via last_owner=3).
- Round-robin: req=4'b1111 held, all len=0, TURNAROUND=1. Required: grant order 0,1,2,3,0 with 3 cycles between grants.
- Burst and stall: requester 2, len=3, bus_ready toggled 1,0,1,1,0,1. Required: exactly 4 beats, data stable across stalls, req_ready[2] pulses match beats, then TURN for 1 cycle.
- Abort: requester 0 drops req after 1 of 5 beats. Required: gnt clears the next edge, no further beats, TURN, then requester 1 is granted if requesting.
- Reset mid-burst: assert rst_n low during beat 2. Required: all outputs 0 immediately without waiting for an edge. After release, requester 0 has priority again.
- TURNAROUND=0: two requesters with len=0. Required: bus_valid pattern 1,0,1 (IDLE cycle only) and gnt never shows two bits set.
